// File: rtl/fsub_adder_if.sv
// Operand/result bundle for the full adder-subtractor.
// Latency 1 clock; no backpressure, a new operation may be presented every cycle.
interface fsub_adder_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic             func;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             in3;
  logic             out_valid;
  logic [WIDTH-1:0] sum_or_difference;
  logic             carry_or_borrow;

  modport master (
    output in_valid, func, in1, in2, in3,
    input  out_valid, sum_or_difference, carry_or_borrow
  );

  modport slave (
    input  in_valid, func, in1, in2, in3,
    output out_valid, sum_or_difference, carry_or_borrow
  );
endinterface

// File: rtl/fsub_adder.sv
// Ripple full adder / subtractor, func=1 adds, func=0 subtracts with borrow.
// Latency 1 clock; no backpressure, results hold while in_valid is low.
module fsub_adder #(
  parameter int WIDTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  fsub_adder_if.slave  bus
);

  typedef struct packed {
    logic             cb;
    logic [WIDTH-1:0] s;
  } res_t;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  res_t             res_d;
  res_t             res_q;
  logic             vld_q;

  assign c[0] = bus.in3;

  // The sum bit is identical in both modes; only the carry/borrow term differs.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic a;
    logic b;
    logic cy_add;
    logic cy_sub;
    assign a      = bus.in1[i];
    assign b      = bus.in2[i];
    assign s[i]   = a ^ b ^ c[i];
    assign cy_add = (a & b) | ((a ^ b) & c[i]);
    assign cy_sub = (~a & (b ^ c[i])) | (b & c[i]);
    assign c[i+1] = bus.func ? cy_add : cy_sub;
  end

  assign res_d.cb = c[WIDTH];
  assign res_d.s  = s;

  // Result register only loads on in_valid, so idle-cycle inputs never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
    end else if (bus.in_valid) begin
      vld_q <= 1'b1;
      res_q <= res_d;
    end else begin
      vld_q <= 1'b0;
    end
  end

  assign bus.out_valid         = vld_q;
  assign bus.sum_or_difference = res_q.s;
  assign bus.carry_or_borrow   = res_q.cb;

endmodule

// File: tb/tb_fsub_adder.sv
// Bench for fsub_adder at WIDTH=1 and WIDTH=8 against an arithmetic reference model.
module tb_fsub_adder;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fsub_adder_if #(.WIDTH(1)) if1 ();
  fsub_adder_if #(.WIDTH(8)) if8 ();

  fsub_adder #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .bus(if1));
  fsub_adder #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .bus(if8));

  // Expected output state of each instance.
  bit     m1_v, m8_v;
  longint m1_s, m8_s;
  bit     m1_c, m8_c;

  // Returns {carry_or_borrow, result} packed as cb at bit w.
  function automatic longint ref_op(int w, bit f, longint a, longint b, bit c);
    longint mask = (longint'(1) << w) - 1;
    longint r;
    longint s;
    bit     cb;
    if (f) begin
      r  = a + b + longint'(c);
      s  = r & mask;
      cb = ((r >> w) & 1) != 0;
    end else begin
      s  = (a - b - longint'(c)) & mask;
      cb = a < (b + longint'(c));
    end
    return (longint'(cb) << w) | s;
  endfunction

  task automatic check(string name, longint got, longint want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, got, want, $time);
    end
  endtask

  // One clock: update the model from the sampled inputs, then compare both DUTs.
  task automatic step();
    longint r;
    @(posedge clk);
    if (rst) begin
      m1_v = 0; m1_s = 0; m1_c = 0;
      m8_v = 0; m8_s = 0; m8_c = 0;
    end else begin
      if (if1.in_valid) begin
        r = ref_op(1, if1.func, longint'(if1.in1), longint'(if1.in2), if1.in3);
        m1_v = 1; m1_s = r & 1; m1_c = ((r >> 1) & 1) != 0;
      end else m1_v = 0;
      if (if8.in_valid) begin
        r = ref_op(8, if8.func, longint'(if8.in1), longint'(if8.in2), if8.in3);
        m8_v = 1; m8_s = r & 255; m8_c = ((r >> 8) & 1) != 0;
      end else m8_v = 0;
    end
    #1;
    check("w1_out_valid", longint'(if1.out_valid), longint'(m1_v));
    check("w1_sum", longint'(if1.sum_or_difference), m1_s);
    check("w1_cb", longint'(if1.carry_or_borrow), longint'(m1_c));
    check("w8_out_valid", longint'(if8.out_valid), longint'(m8_v));
    check("w8_sum", longint'(if8.sum_or_difference), m8_s);
    check("w8_cb", longint'(if8.carry_or_borrow), longint'(m8_c));
  endtask

  task automatic drive8(bit v, bit f, logic [7:0] a, logic [7:0] b, bit c);
    if8.in_valid = v; if8.func = f; if8.in1 = a; if8.in2 = b; if8.in3 = c;
  endtask

  task automatic lit8(string name, bit v, logic [7:0] s, bit c);
    check({name, "_valid"}, longint'(if8.out_valid), longint'(v));
    check({name, "_sum"}, longint'(if8.sum_or_difference), longint'(s));
    check({name, "_cb"}, longint'(if8.carry_or_borrow), longint'(c));
  endtask

  int   row_idx [6] = '{0, 2, 4, 7, 11, 15};
  bit   row_s   [6] = '{0, 1, 1, 1, 0, 1};
  bit   row_c   [6] = '{0, 1, 0, 1, 1, 1};

  initial begin
    logic [3:0] v4;
    rst = 1'b1;
    if1.in_valid = 1'b1; if1.func = 1'b1; if1.in1 = 1'b1; if1.in2 = 1'b1; if1.in3 = 1'b1;
    drive8(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    step();
    lit8("reset", 1'b0, 8'h00, 1'b0);
    step();
    rst = 1'b0;

    // Exhaustive WIDTH=1 sweep, one combination per cycle.
    for (int i = 0; i < 16; i++) begin
      v4 = 4'(i);
      if1.in_valid = 1'b1;
      {if1.func, if1.in1, if1.in2, if1.in3} = v4;
      step();
      for (int k = 0; k < 6; k++) begin
        if (row_idx[k] == i) begin
          check($sformatf("sweep%0d_sum", i), longint'(if1.sum_or_difference), longint'(row_s[k]));
          check($sformatf("sweep%0d_cb", i), longint'(if1.carry_or_borrow), longint'(row_c[k]));
        end
      end
    end
    if1.in_valid = 1'b0;

    // WIDTH=8 boundary cases.
    drive8(1'b1, 1'b1, 8'hFF, 8'h01, 1'b0); step(); lit8("add_wrap", 1'b1, 8'h00, 1'b1);
    drive8(1'b1, 1'b0, 8'h00, 8'h01, 1'b0); step(); lit8("sub_wrap", 1'b1, 8'hFF, 1'b1);
    drive8(1'b1, 1'b0, 8'h10, 8'h05, 1'b1); step(); lit8("sub_bin", 1'b1, 8'h0A, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive8(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      step();
      lit8($sformatf("hold%0d", i), 1'b0, 8'h0A, 1'b0);
    end
    rst = 1'b1;
    drive8(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    step();
    lit8("rst_prio", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    drive8(1'b1, 1'b1, 8'h12, 8'h34, 1'b1); step(); lit8("post_rst", 1'b1, 8'h47, 1'b0);

    // Randomized back-to-back traffic with occasional mid-stream reset.
    for (int i = 0; i < 1000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      drive8($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      if1.in_valid = ($urandom_range(0, 3) != 0);
      if1.func = 1'($urandom); if1.in1 = 1'($urandom);
      if1.in2 = 1'($urandom); if1.in3 = 1'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fsub_adder.md
FSUB_ADDER -- requirements
Module: fsub_adder

Interface
REQ-001 Parameter: WIDTH, default 1, operand width in bits (legal range 1..64).
REQ-002 Interface: one clock; reset is synchronous and active-high.
REQ-003 Port: clk  input  1  rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous active-high reset.
REQ-005 Port: in_valid  input  1  operands and func are sampled on this clock edge.
REQ-006 Port: func  input  1  operation select: 1 = add, 0 = subtract.
REQ-007 Port: in1  input  WIDTH  operand A (minuend or addend).
REQ-008 Port: in2  input  WIDTH  operand B (subtrahend or addend).
REQ-009 Port: in3  input  1  carry-in (add) or borrow-in (subtract).
REQ-010 Port: out_valid  output  1  registered result valid.
REQ-011 Port: sum_or_difference  output  WIDTH  registered sum or difference.
REQ-012 Port: carry_or_borrow  output  1  registered carry-out (add) or borrow-out (subtract).

Function
REQ-013 Add (func=1): {carry_or_borrow, sum_or_difference} SHALL equal in1 + in2 + in3, computed at WIDTH+1 bits.
REQ-014 Subtract (func=0): sum_or_difference SHALL equal (in1 - in2 - in3) mod 2^WIDTH.
REQ-015 Subtract: carry_or_borrow SHALL be 1 iff in1 < in2 + in3 as unsigned integers, otherwise 0.
REQ-016 Per bit i (ripple form): s_i = a_i ^ b_i ^ c_i for both modes.
REQ-017 Add carry per bit: c_(i+1) = (a_i & b_i) | ((a_i ^ b_i) & c_i).
REQ-018 Subtract borrow per bit: c_(i+1) = (~a_i & (b_i ^ c_i)) | (b_i & c_i).
REQ-019 In both modes, c_0 = in3.
REQ-020 Latency SHALL be exactly 1 clock.
REQ-021 On a rising edge with in_valid=1 and rst=0, outputs SHALL load the result of the sampled func/in1/in2/in3, and out_valid SHALL be 1 in the following cycle.
REQ-022 On a rising edge with in_valid=0 and rst=0, sum_or_difference and carry_or_borrow SHALL hold their previous values, and out_valid SHALL be 0 in the following cycle.
REQ-023 No back-pressure: a new operation SHALL be accepted every cycle, including back-to-back operations with func toggling.
REQ-024 Overflow SHALL wrap at all-ones and at zero; the wrap is signalled only via carry_or_borrow, with no saturation.
REQ-025 X on inputs while in_valid=0 SHALL NOT propagate to the outputs.

Reset
REQ-026 When rst=1 at a rising edge, out_valid, sum_or_difference and carry_or_borrow SHALL all be 0 in the next cycle.
REQ-027 Reset SHALL take priority over in_valid; an operation presented in the same cycle as rst is discarded.
REQ-028 Reset asserted mid-stream SHALL discard the in-flight result; the first valid input after reset deasserts produces a result 1 cycle later.

Verification
REQ-029 Exhaustive WIDTH=1 sweep: step {func,in1,in2,in3} from 0000 to 1111, one per cycle -> sum/borrow rows 0000->0/0, 0010->1/1, 0100->1/0, 0111->1/1; add rows 1011->0/1, 1111->1/1.
REQ-030 WIDTH=8 add: in1=0xFF, in2=0x01, in3=0 -> sum_or_difference=0x00, carry_or_borrow=1.
REQ-031 WIDTH=8 subtract: in1=0x00, in2=0x01, in3=0 -> sum_or_difference=0xFF, carry_or_borrow=1.
REQ-032 WIDTH=8 subtract: in1=0x10, in2=0x05, in3=1 -> sum_or_difference=0x0A, carry_or_borrow=0.
REQ-033 Hold and reset: valid op, then in_valid=0 for 3 cycles -> outputs hold and out_valid=0; then rst=1 together with in_valid=1 -> all outputs 0 next cycle.
REQ-034 Randomized back-to-back operations (WIDTH=8, 1000 cycles) -> every result matches the REQ-013..REQ-015 reference model with 1-cycle latency.
